// File: rtl/alu_if.sv
// ALU operand/result bundle.
// Master drives operands, slave returns results.
interface alu_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  localparam int OW = DATA_WIDTH - ADDR_WIDTH;

  logic [OW-1:0]         opcode;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [DATA_WIDTH-1:0] result;
  logic                  is_zero;

  modport master (
    output opcode,
    output in_a,
    output in_b,
    input  result,
    input  is_zero
  );

  modport slave (
    input  opcode,
    input  in_a,
    input  in_b,
    output result,
    output is_zero
  );
endinterface

// File: rtl/alu.sv
// Accumulator ALU with registered result.
// is_zero tracks in_a, not result.
module alu #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);
  localparam int OW = DATA_WIDTH - ADDR_WIDTH;

  localparam logic [OW-1:0] OP_ADD = OW'(2);
  localparam logic [OW-1:0] OP_AND = OW'(3);
  localparam logic [OW-1:0] OP_XOR = OW'(4);
  localparam logic [OW-1:0] OP_LDA = OW'(5);

  logic [DATA_WIDTH-1:0] res_d;

  // HLT, SKZ, STO, JMP and unknown codes pass in_a
  always_comb begin
    res_d = bus.in_a;
    case (bus.opcode)
      OP_ADD:  res_d = bus.in_a + bus.in_b;
      OP_AND:  res_d = bus.in_a & bus.in_b;
      OP_XOR:  res_d = bus.in_a ^ bus.in_b;
      OP_LDA:  res_d = bus.in_b;
      default: res_d = bus.in_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result  <= '0;
      bus.is_zero <= 1'b0;
    end else begin
      bus.result  <= res_d;
      bus.is_zero <= (bus.in_a == '0);
    end
  end
endmodule

// File: tb/tb_alu.sv
// Directed bench for alu.
// Inputs change 1ns after posedge, outputs sampled there too.
module tb_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

  alu #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic       r,
                      input logic [2:0] op,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input string      tag,
                      input logic [7:0] exp_res,
                      input logic       exp_z);
    rst        = r;
    bus.opcode = op;
    bus.in_a   = a;
    bus.in_b   = b;
    @(posedge clk);
    #1;
    chk({tag, ".result"}, bus.result, exp_res);
    chk({tag, ".is_zero"}, {7'd0, bus.is_zero}, {7'd0, exp_z});
  endtask

  initial begin
    bus.opcode = 3'd0;
    bus.in_a   = 8'h00;
    bus.in_b   = 8'h00;
    @(negedge clk);
    // reset with in_a=0 so is_zero must stay low
    step(1, 3'b010, 8'h00, 8'hFF, "rst0", 8'h00, 1'b0);
    step(1, 3'b100, 8'h5A, 8'hA5, "rst1", 8'h00, 1'b0);
    step(0, 3'b000, 8'h37, 8'hDA, "hlt", 8'h37, 1'b0);
    step(0, 3'b001, 8'h37, 8'hDA, "skz", 8'h37, 1'b0);
    step(0, 3'b110, 8'h37, 8'hDA, "sto", 8'h37, 1'b0);
    step(0, 3'b111, 8'h37, 8'hDA, "jmp", 8'h37, 1'b0);
    step(0, 3'b010, 8'h37, 8'hDA, "add", 8'h11, 1'b0);
    step(0, 3'b011, 8'h37, 8'hDA, "and", 8'h12, 1'b0);
    step(0, 3'b100, 8'h37, 8'hDA, "xor", 8'hED, 1'b0);
    step(0, 3'b101, 8'h37, 8'hDA, "lda", 8'hDA, 1'b0);
    step(0, 3'b010, 8'h00, 8'hFF, "zero", 8'hFF, 1'b1);
    step(0, 3'b000, 8'h01, 8'hFF, "nz", 8'h01, 1'b0);
    step(0, 3'b010, 8'hFF, 8'h01, "addwrap", 8'h00, 1'b0);
    step(0, 3'b101, 8'h00, 8'h3C, "ldaz", 8'h3C, 1'b1);
    step(0, 3'b010, 8'h37, 8'hDA, "b2b_add", 8'h11, 1'b0);
    step(1, 3'b011, 8'h00, 8'hDA, "b2b_rst", 8'h00, 1'b0);
    step(0, 3'b100, 8'h37, 8'hDA, "b2b_xor", 8'hED, 1'b0);
    // outputs must hold between edges
    #3;
    chk("hold.result", bus.result, 8'hED);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
